// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encoding
// and a small helper that classifies operations.
package usr_pkg;

    localparam int MODE_W = 3;

    // Operation selected by Mode
    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LSR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    // True for the operations that move data by one bit position
    function automatic logic is_shift_class(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_LSR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

    // True for the operations that restart the shift count
    function automatic logic is_count_zero(input mode_e m);
        return (m == MODE_LOAD) || (m == MODE_CLEAR);
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Modulo-WIDTH shift counter with a registered one-cycle completion pulse.
// Wrap rises for the single cycle after the step that returns Count to 0.
module usr_shift_counter #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          Clock,
    input  logic          ResetN,
    input  logic          step,
    input  logic          zero,
    output logic [CW-1:0] Count,
    output logic          Wrap
);

    import usr_pkg::*;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;
    logic          r_wrap;
    logic [CW-1:0] w_count_nxt;
    logic          w_wrap_nxt;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);

    // Next count/wrap: explicit wrap at WIDTH-1 so non-power-of-two widths stay in range
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (zero) begin
            w_count_nxt = '0;
        end else if (step) begin
            if (w_at_last) begin
                w_count_nxt = '0;
                w_wrap_nxt  = 1'b1;
            end else begin
                w_count_nxt = r_count + CW'(1);
            end
        end
    end

    // Count and wrap registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign Count = r_count;
    assign Wrap  = r_wrap;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, parallel load, logical/arithmetic shifts,
// rotates and clear, with a modulo-WIDTH shift counter and wrap pulse.
module universal_shift_register #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic                      Clock,
    input  logic                      ResetN,
    input  logic                      Enable,
    input  logic [usr_pkg::MODE_W-1:0] Mode,
    input  logic [WIDTH-1:0]          D,
    input  logic                      SerialInRight,
    input  logic                      SerialInLeft,
    output logic [WIDTH-1:0]          Q,
    output logic                      SerialOutLeft,
    output logic                      SerialOutRight,
    output logic [CW-1:0]             Count,
    output logic                      Wrap
);

    import usr_pkg::*;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    mode_e            w_mode;
    logic             w_step;
    logic             w_zero;

    assign w_mode = mode_e'(Mode);
    assign w_step = Enable && is_shift_class(w_mode);
    assign w_zero = Enable && is_count_zero(w_mode);

    // Data path next-state selection by operation
    always_comb begin
        w_q_nxt = r_q;
        if (Enable) begin
            unique case (w_mode)
                MODE_HOLD:  w_q_nxt = r_q;
                MODE_LOAD:  w_q_nxt = D;
                MODE_SHL:   w_q_nxt = {r_q[WIDTH-2:0], SerialInRight};
                MODE_LSR:   w_q_nxt = {SerialInLeft, r_q[WIDTH-1:1]};
                MODE_ROL:   w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                MODE_ROR:   w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                MODE_ASR:   w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                MODE_CLEAR: w_q_nxt = '0;
                default:    w_q_nxt = r_q;
            endcase
        end
    end

    // Data register with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    usr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .Clock  (Clock),
        .ResetN (ResetN),
        .step   (w_step),
        .zero   (w_zero),
        .Count  (Count),
        .Wrap   (Wrap)
    );

    assign Q              = r_q;
    assign SerialOutLeft  = r_q[WIDTH-1];
    assign SerialOutRight = r_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed, table-driven bench for universal_shift_register at WIDTH=8.
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH);

    logic             Clock;
    logic             ResetN;
    logic             Enable;
    logic [2:0]       Mode;
    logic [WIDTH-1:0] D;
    logic             SerialInRight;
    logic             SerialInLeft;
    logic [WIDTH-1:0] Q;
    logic             SerialOutLeft;
    logic             SerialOutRight;
    logic [CW-1:0]    Count;
    logic             Wrap;

    int n_pass  = 0;
    int n_total = 0;

    universal_shift_register #(
        .WIDTH (WIDTH)
    ) dut (
        .Clock          (Clock),
        .ResetN         (ResetN),
        .Enable         (Enable),
        .Mode           (Mode),
        .D              (D),
        .SerialInRight  (SerialInRight),
        .SerialInLeft   (SerialInLeft),
        .Q              (Q),
        .SerialOutLeft  (SerialOutLeft),
        .SerialOutRight (SerialOutRight),
        .Count          (Count),
        .Wrap           (Wrap)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string            name;
        logic             rn;
        logic             en;
        logic [2:0]       mode;
        logic [WIDTH-1:0] d;
        logic             sir;
        logic             sil;
        logic [WIDTH-1:0] exp_q;
        logic [CW-1:0]    exp_cnt;
        logic             exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic rn, input logic en,
                       input logic [2:0] md, input logic [WIDTH-1:0] dd,
                       input logic sir, input logic sil,
                       input logic [WIDTH-1:0] eq, input logic [CW-1:0] ec,
                       input logic ew);
        vec_t v;
        v.name = nm; v.rn = rn; v.en = en; v.mode = md; v.d = dd;
        v.sir = sir; v.sil = sil; v.exp_q = eq; v.exp_cnt = ec; v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic rn, input logic en, input logic [2:0] md,
                         input logic [WIDTH-1:0] dd, input logic sir, input logic sil);
        ResetN = rn; Enable = en; Mode = md; D = dd;
        SerialInRight = sir; SerialInLeft = sil;
    endtask

    // Apply one edge and sample 1 time unit after it
    task automatic step_edge();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all(input string nm, input logic [WIDTH-1:0] eq,
                             input logic [CW-1:0] ec, input logic ew);
        logic [WIDTH-1:0] tmp;
        tmp = eq;
        check({nm, ".Q"},     64'(Q),              64'(eq));
        check({nm, ".Count"}, 64'(Count),          64'(ec));
        check({nm, ".Wrap"},  64'(Wrap),           64'(ew));
        check({nm, ".SOL"},   64'(SerialOutLeft),  64'(tmp[WIDTH-1]));
        check({nm, ".SOR"},   64'(SerialOutRight), 64'(tmp[0]));
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'b000, '0, 1'b0, 1'b0);

        //    name          rn en mode    D      sir sil  expQ   cnt wrap
        add("reset",       0, 1, 3'b001, 8'hA5, 0, 0, 8'h00, 0, 0);
        add("load_a5",     1, 1, 3'b001, 8'hA5, 0, 0, 8'hA5, 0, 0);
        add("gate1",       1, 0, 3'b010, 8'h00, 0, 0, 8'hA5, 0, 0);
        add("gate2",       1, 0, 3'b010, 8'h00, 1, 1, 8'hA5, 0, 0);
        add("gate3",       1, 0, 3'b010, 8'h00, 0, 0, 8'hA5, 0, 0);
        add("gate_clr",    1, 0, 3'b111, 8'h00, 0, 0, 8'hA5, 0, 0);
        add("load_81a",    1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0);
        add("shl",         1, 1, 3'b010, 8'h00, 0, 0, 8'h02, 1, 0);
        add("load_81b",    1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0);
        add("rol",         1, 1, 3'b100, 8'h00, 0, 0, 8'h03, 1, 0);
        add("load_81c",    1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0);
        add("ror",         1, 1, 3'b101, 8'h00, 0, 0, 8'hC0, 1, 0);
        add("load_81d",    1, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0);
        add("lsr",         1, 1, 3'b011, 8'h00, 0, 0, 8'h40, 1, 0);
        add("load_90",     1, 1, 3'b001, 8'h90, 0, 0, 8'h90, 0, 0);
        add("asr",         1, 1, 3'b110, 8'h00, 0, 0, 8'hC8, 1, 0);
        add("hold1",       1, 1, 3'b000, 8'hFF, 1, 1, 8'hC8, 1, 0);
        add("hold2",       1, 1, 3'b000, 8'hFF, 1, 1, 8'hC8, 1, 0);
        add("hold3",       1, 1, 3'b000, 8'hFF, 1, 1, 8'hC8, 1, 0);
        add("hold4",       1, 1, 3'b000, 8'hFF, 1, 1, 8'hC8, 1, 0);
        add("clear",       1, 1, 3'b111, 8'hFF, 1, 1, 8'h00, 0, 0);
        add("shl_sir1",    1, 1, 3'b010, 8'h00, 1, 0, 8'h01, 1, 0);
        add("lsr_sil1",    1, 1, 3'b011, 8'h00, 0, 1, 8'h80, 2, 0);
        add("asr_neg",     1, 1, 3'b110, 8'h00, 0, 0, 8'hC0, 3, 0);
        add("ror_lsb",     1, 1, 3'b101, 8'h00, 0, 0, 8'h60, 4, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rn, vecs[i].en, vecs[i].mode, vecs[i].d,
                  vecs[i].sir, vecs[i].sil);
            step_edge();
            check_all(vecs[i].name, vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_wrap);
        end

        // Wrap: load 01 then 8 shift-lefts filling with 1s
        begin
            logic [WIDTH-1:0] eq;
            drive(1'b1, 1'b1, 3'b001, 8'h01, 1'b0, 1'b0);
            step_edge();
            check_all("wrap_load", 8'h01, 0, 0);
            eq = 8'h01;
            for (int k = 1; k <= 8; k++) begin
                drive(1'b1, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
                step_edge();
                eq = {eq[WIDTH-2:0], 1'b1};
                check_all($sformatf("wrap_shl%0d", k), eq, CW'(k % 8), (k == 8));
            end
            drive(1'b1, 1'b0, 3'b010, 8'h00, 1'b1, 1'b0);
            step_edge();
            check_all("wrap_fall", 8'hFF, 0, 0);
        end

        // Reset mid-sequence discards the partial count and never wraps
        begin
            drive(1'b1, 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0);
            step_edge();
            for (int k = 1; k <= 5; k++) begin
                drive(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
                step_edge();
                check($sformatf("mid_cnt%0d", k), 64'(Count), 64'(k));
                check($sformatf("mid_wrap%0d", k), 64'(Wrap), 64'(0));
            end
            drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b1);
            step_edge();
            check_all("mid_reset", 8'h00, 0, 0);
            for (int k = 1; k <= 3; k++) begin
                drive(1'b1, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
                step_edge();
                check($sformatf("post_cnt%0d", k), 64'(Count), 64'(k));
                check($sformatf("post_wrap%0d", k), 64'(Wrap), 64'(0));
            end
            check("post_q", 64'(Q), 64'(8'h07));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
